datapath_ctrl_fsm: RTL

- Hard-wired control unit for the single-bus datapath.
- Sequences fetch (T0–T2) and execute (T3–T6) of register-to-register ALU instructions by driving the datapath's bus-select, register-load and ALU operation strobes.
- Waits on memory through a ready handshake, retires instructions, and flags illegal opcodes and memory timeouts.
- Replaces the hand-timed strobe sequences currently used to exercise the datapath.

---
 rtl/datapath_ctrl_fsm.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/datapath_ctrl_fsm.sv
// Hard-wired control unit for the single-bus datapath: sequences fetch
// (T0-T2) and execute (T3-T6) of register-to-register ALU instructions.
// Optional mul/div support is enabled by defining DATAPATH_CTRL_MULDIV_EN.
module datapath_ctrl_fsm #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic             mem_ready,
    input  logic [31:0]      ir,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             PCin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             ZLOin,
    output logic             ZHIin,
    output logic             ZLowout,
    output logic             ZHighout,
    output logic             HIin,
    output logic             LOin,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic [4:0]       operation,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic             mem_fault,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned WAIT_W    = 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

`ifdef DATAPATH_CTRL_MULDIV_EN
    localparam bit MULDIV_EN = 1'b1;
`else
    localparam bit MULDIV_EN = 1'b0;
`endif

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_SHR = 5'b00101;
    localparam logic [4:0] OP_SHL = 5'b00110;
    localparam logic [4:0] OP_ROR = 5'b00111;
    localparam logic [4:0] OP_ROL = 5'b01000;
    localparam logic [4:0] OP_AND = 5'b01001;
    localparam logic [4:0] OP_OR  = 5'b01010;
    localparam logic [4:0] OP_MUL = 5'b01110;
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam logic [4:0] OP_NEG = 5'b10000;
    localparam logic [4:0] OP_NOT = 5'b10001;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_FAULT
    } state_t;

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [4:0]          opcode;
    logic                op_legal;
    logic                op_unary;
    logic                op_muldiv;
    logic [CNT_W-1:0]    count_next;
    logic                unused_ir;

    assign opcode     = ir[31:27];
    assign unused_ir  = ^ir[26:0];
    assign count_next = (&instr_count) ? instr_count : instr_count + CNT_W'(1);
    assign busy       = (state != S_IDLE) && (state != S_FAULT);

    // Opcode classification; mul/div only count when the feature is built in
    always_comb begin
        op_legal  = 1'b0;
        op_unary  = (opcode == OP_NEG) || (opcode == OP_NOT);
        op_muldiv = MULDIV_EN && ((opcode == OP_MUL) || (opcode == OP_DIV));
        case (opcode)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
            OP_AND, OP_OR, OP_NEG, OP_NOT: op_legal = 1'b1;
            default:                       op_legal = op_muldiv;
        endcase
    end

    // Sequencer: state, memory wait counter, retire and sticky status flags
    always_ff @(posedge clk) begin
        if (!clr) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            instr_count <= '0;
            illegal     <= 1'b0;
            mem_fault   <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state <= S_T0;
                    end
                end
                S_T0: begin
                    state <= S_T1;
                end
                S_T1: begin
                    if (mem_ready) begin
                        state    <= S_T2;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state     <= S_FAULT;
                        mem_fault <= 1'b1;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_T2: begin
                    state <= S_T3;
                end
                S_T3: begin
                    if (op_legal) begin
                        state <= S_T4;
                    end else begin
                        illegal <= 1'b1;
                        state   <= S_FAULT;
                    end
                end
                S_T4: begin
                    state <= S_T5;
                end
                S_T5: begin
                    if (op_muldiv) begin
                        state <= S_T6;
                    end else begin
                        done        <= 1'b1;
                        instr_count <= count_next;
                        state       <= run ? S_T0 : S_IDLE;
                    end
                end
                S_T6: begin
                    done        <= 1'b1;
                    instr_count <= count_next;
                    state       <= run ? S_T0 : S_IDLE;
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore strobe decode from state and opcode; everything held low while clr is low
    always_comb begin
        PCout     = 1'b0;
        MARin     = 1'b0;
        IncPC     = 1'b0;
        PCin      = 1'b0;
        Read      = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        ZLOin     = 1'b0;
        ZHIin     = 1'b0;
        ZLowout   = 1'b0;
        ZHighout  = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        Gra       = 1'b0;
        Grb       = 1'b0;
        Grc       = 1'b0;
        Rin       = 1'b0;
        Rout      = 1'b0;
        operation = 5'd0;
        if (clr) begin
            case (state)
                S_T0: begin
                    PCout = 1'b1;
                    MARin = 1'b1;
                    IncPC = 1'b1;
                    ZLOin = 1'b1;
                end
                S_T1: begin
                    ZLowout = 1'b1;
                    PCin    = 1'b1;
                    Read    = 1'b1;
                    MDRin   = 1'b1;
                end
                S_T2: begin
                    MDRout = 1'b1;
                    IRin   = 1'b1;
                end
                S_T3: begin
                    Grb  = op_legal;
                    Rout = op_legal;
                    Yin  = op_legal;
                end
                S_T4: begin
                    Rout      = 1'b1;
                    ZLOin     = 1'b1;
                    Grb       = op_unary;
                    Grc       = !op_unary;
                    ZHIin     = op_muldiv;
                    operation = opcode;
                end
                S_T5: begin
                    ZLowout = 1'b1;
                    LOin    = op_muldiv;
                    Gra     = !op_muldiv;
                    Rin     = !op_muldiv;
                end
                S_T6: begin
                    ZHighout = MULDIV_EN;
                    HIin     = MULDIV_EN;
                end
                default: begin
                    operation = 5'd0;
                end
            endcase
        end
    end

endmodule
